// File: rtl/vmem_pkg.sv
// Shared types and default geometry for the vector memory sequencer.
// No logic; optional strided addressing is selected by VSEQ_STRIDE_EN.
// No flow control of its own.
package vmem_pkg;
    localparam int VSEQ_LANES  = 4;
    localparam int VSEQ_DATA_W = 8;
    localparam int VSEQ_ADDR_W = 16;
    localparam int VSEQ_IDX_W  = (VSEQ_LANES > 1) ? $clog2(VSEQ_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } vseq_state_t;
endpackage

// File: rtl/vseq_addr_gen.sv
// Element address generator: base + idx*stride (VSEQ_STRIDE_EN) or base + idx, wrapped to ADDR_W.
// Purely combinational, zero latency.
// No backpressure.
module vseq_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  idx,
`ifdef VSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic [ADDR_W-1:0] addr
);
    always_comb begin
`ifdef VSEQ_STRIDE_EN
        addr = base + ADDR_W'(idx) * stride;
`else
        addr = base + ADDR_W'(idx);
`endif
    end
endmodule

// File: rtl/vector_mem_sequencer.sv
// Serialises one vector load/store into LANES scalar accesses; VSEQ_STRIDE_EN adds req_stride.
// Latency: store done LANES+1 cycles after acceptance, load LANES+2 (extra drain for sync read).
// Backpressure: stall held from acceptance until the DONE cycle; req_* ignored after acceptance.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int LANES  = VSEQ_LANES,
    parameter int DATA_W = VSEQ_DATA_W,
    parameter int ADDR_W = VSEQ_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*DATA_W-1:0] req_wdata,
`ifdef VSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0]       req_stride,
`endif
    output logic                    stall,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] rdata_vec
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    vseq_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    write_q;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] wdata_q;
`ifdef VSEQ_STRIDE_EN
    logic [ADDR_W-1:0]       stride_q;
    logic [ADDR_W-1:0]       gen_stride;
`endif
    logic                    stall_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic                    done_q;
    logic                    cap_vld;
    logic [IDX_W-1:0]        cap_idx;
    logic [ADDR_W-1:0]       gen_base;
    logic [IDX_W-1:0]        gen_idx;
    logic [ADDR_W-1:0]       gen_addr;

    assign idx_nxt = idx + IDX_W'(1);

    // Address of the lane issued next cycle: lane 0 of the incoming request, else idx+1.
    always_comb begin
        gen_base = base_q;
        gen_idx  = idx_nxt;
`ifdef VSEQ_STRIDE_EN
        gen_stride = stride_q;
`endif
        if (state == IDLE) begin
            gen_base = req_addr;
            gen_idx  = '0;
`ifdef VSEQ_STRIDE_EN
            gen_stride = req_stride;
`endif
        end
    end

    vseq_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .base   (gen_base),
        .idx    (gen_idx),
`ifdef VSEQ_STRIDE_EN
        .stride (gen_stride),
`endif
        .addr   (gen_addr)
    );

    // Gating with rst keeps the port quiet during the reset cycle, so no lane is written then.
    assign stall  = (state == IDLE) ? (req_valid & ~rst) : (stall_q & ~rst);
    assign mem_en = mem_en_q & ~rst;
    assign mem_we = mem_we_q & ~rst;
    assign done   = done_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            write_q   <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
`ifdef VSEQ_STRIDE_EN
            stride_q  <= '0;
`endif
            stall_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done_q    <= 1'b0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            rdata_vec <= '0;
        end else begin
            cap_vld <= 1'b0;
            if (cap_vld) begin
                rdata_vec[cap_idx*DATA_W +: DATA_W] <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req_valid) begin
                        write_q   <= req_write;
                        base_q    <= req_addr;
                        wdata_q   <= req_wdata;
`ifdef VSEQ_STRIDE_EN
                        stride_q  <= req_stride;
`endif
                        idx       <= '0;
                        stall_q   <= 1'b1;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= req_write;
                        mem_addr  <= gen_addr;
                        mem_wdata <= req_wdata[DATA_W-1:0];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cap_vld <= ~write_q;
                    cap_idx <= idx;
                    if (idx == LAST) begin
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (write_q) begin
                            done_q  <= 1'b1;
                            stall_q <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx       <= idx_nxt;
                        mem_addr  <= gen_addr;
                        mem_wdata <= wdata_q[idx_nxt*DATA_W +: DATA_W];
                    end
                end
                DRAIN: begin
                    done_q  <= 1'b1;
                    stall_q <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Bench for vector_mem_sequencer with a 1-cycle synchronous-read memory and a reference model.
// Build with VSEQ_STRIDE_EN to exercise strided addressing.
module tb_vector_mem_sequencer;
    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b1;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
`ifdef VSEQ_STRIDE_EN
    logic [15:0] req_stride = 16'd1;
`endif
    logic        stall, mem_en, mem_we, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [31:0] rdata_vec;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef VSEQ_STRIDE_EN
        .req_stride(req_stride),
`endif
        .stall     (stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .done      (done),
        .rdata_vec (rdata_vec)
    );

    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [15:0] lane_addr(input logic [15:0] base, input logic [15:0] stride, input int k);
        logic [31:0] full;
        full = 32'(base) + 32'(k) * 32'(stride);
        return full[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_req();
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
`ifdef VSEQ_STRIDE_EN
        req_stride = 16'($urandom);
`endif
    endtask

    // One full vector operation from acceptance (cycle 0) to its DONE cycle.
    task automatic run_op(input logic wr, input logic [15:0] base, input logic [15:0] stride,
                          input logic [31:0] wdata, input bit keep);
        int last;
        logic [31:0] exp_r;
        logic [15:0] ea;
        logic [7:0]  ed;
        last = wr ? LANES + 1 : LANES + 2;
        for (int k = 0; k < LANES; k++) exp_r[k*8 +: 8] = ref_mem[lane_addr(base, stride, k)];
        step();
        req_valid = 1'b1; req_write = wr; req_addr = base; req_wdata = wdata;
`ifdef VSEQ_STRIDE_EN
        req_stride = stride;
`endif
        #1;
        checks++;
        if (stall !== 1'b1 || mem_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept: stall=%b en=%b done=%b, want stall=1 en=0 done=0", stall, mem_en, done);
        end
        for (int c = 1; c <= last; c++) begin
            step();
            randomize_req();
            req_valid = keep ? 1'b1 : 1'($urandom);
            #1;
            checks++;
            if (c <= LANES) begin
                ea = lane_addr(base, stride, c - 1);
                ed = wdata[(c-1)*8 +: 8];
                if (mem_en !== 1'b1 || mem_we !== wr || mem_addr !== ea || (wr && mem_wdata !== ed)
                    || stall !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL issue lane %0d: en=%b we=%b addr=%h wdata=%h stall=%b done=%b, want en=1 we=%b addr=%h wdata=%h stall=1 done=0",
                             c - 1, mem_en, mem_we, mem_addr, mem_wdata, stall, done, wr, ea, ed);
                end
            end else if (c < last) begin
                if (mem_en !== 1'b0 || mem_we !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL drain: en=%b we=%b stall=%b done=%b, want en=0 we=0 stall=1 done=0",
                             mem_en, mem_we, stall, done);
                end
            end else begin
                if (done !== 1'b1 || stall !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0
                    || (!wr && rdata_vec !== exp_r)) begin
                    errors++;
                    $display("FAIL done cycle: done=%b stall=%b en=%b we=%b rdata=%h, want done=1 stall=0 en=0 we=0 rdata=%h",
                             done, stall, mem_en, mem_we, rdata_vec, wr ? rdata_vec : exp_r);
                end
            end
        end
        if (wr) for (int k = 0; k < LANES; k++) ref_mem[lane_addr(base, stride, k)] = wdata[k*8 +: 8];
    endtask

    task automatic idle_cycle();
        step();
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle: stall=%b en=%b we=%b done=%b, want all 0", stall, mem_en, mem_we, done);
        end
    endtask

    task automatic check_mem(input logic [15:0] base, input logic [15:0] stride);
        logic [15:0] a;
        for (int k = 0; k < LANES; k++) begin
            a = lane_addr(base, stride, k);
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL memory[%h]: got %h want %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1;
        repeat (3) step();
        checks++;
        if (stall !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0
            || mem_addr !== 16'h0 || mem_wdata !== 8'h0 || rdata_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: stall=%b en=%b we=%b done=%b addr=%h wdata=%h rdata=%h, want all 0",
                     stall, mem_en, mem_we, done, mem_addr, mem_wdata, rdata_vec);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset release stall: got %b want 1", stall);
        end
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall follows req_valid: got %b want 0", stall);
        end
        idle_cycle();
    endtask

    task automatic test_store();
        run_op(1'b1, 16'h0010, 16'd1, 32'h44332211, 1'b0);
        checks++;
        if ({mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} !== 32'h44332211) begin
            errors++;
            $display("FAIL store memory: got %h want 44332211",
                     {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]});
        end
        idle_cycle();
    endtask

    task automatic test_load();
        logic [31:0] pre;
        pre = 32'hDDCCBBAA;
        for (int k = 0; k < 4; k++) begin
            mem[16'h20 + 16'(k)]     = pre[k*8 +: 8];
            ref_mem[16'h20 + 16'(k)] = pre[k*8 +: 8];
        end
        run_op(1'b0, 16'h0020, 16'd1, 32'h0, 1'b0);
        checks++;
        if (rdata_vec !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL load result: got %h want ddccbbaa", rdata_vec);
        end
        idle_cycle();
    endtask

    task automatic test_wrap();
        run_op(1'b1, 16'hFFFE, 16'd1, $urandom, 1'b0);
        check_mem(16'hFFFE, 16'd1);
        idle_cycle();
`ifdef VSEQ_STRIDE_EN
        run_op(1'b1, 16'h0100, 16'd2, $urandom, 1'b0);
        check_mem(16'h0100, 16'd2);
        idle_cycle();
        run_op(1'b0, 16'h0100, 16'd2, 32'h0, 1'b0);
        idle_cycle();
        run_op(1'b0, 16'h0300, 16'd0, 32'h0, 1'b0);
        idle_cycle();
`endif
    endtask

    task automatic test_mid_reset();
        logic [15:0] base;
        logic [31:0] wd;
        base = 16'h4000 + 16'($urandom_range(0, 255));
        wd = $urandom;
        wd[23:16] = ~ref_mem[base + 16'd2];
        wd[31:24] = ~ref_mem[base + 16'd3];
        step();
        req_valid = 1'b1; req_write = 1'b1; req_addr = base; req_wdata = wd;
`ifdef VSEQ_STRIDE_EN
        req_stride = 16'd1;
`endif
        step(); req_valid = 1'b0;
        step();
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after mid reset: stall=%b en=%b we=%b done=%b, want all 0", stall, mem_en, mem_we, done);
        end
        idle_cycle();
        idle_cycle();
        ref_mem[base]         = wd[7:0];
        ref_mem[base + 16'd1] = wd[15:8];
        check_mem(base, 16'd1);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        run_op(1'b0, 16'($urandom), 16'd1, 32'h0, 1'b1);
        run_op(1'b0, 16'($urandom), 16'd1, 32'h0, 1'b1);
        idle_cycle();
        step();
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL back-to-back done pulses: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_random();
        logic wr;
        logic [15:0] base, stride;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom);
            base = 16'($urandom);
            stride = 16'd1;
`ifdef VSEQ_STRIDE_EN
            stride = (n % 5 == 0) ? 16'd0 : 16'($urandom_range(0, 300));
`endif
            run_op(wr, base, stride, $urandom, 1'($urandom));
            if (wr) check_mem(base, stride);
            if (n % 3 == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
